// File: rtl/mod3_serial_tx_if.sv
// mod3_serial_tx_if: word handshake in, serial stream plus running mod-3 status out.
// The transmitter takes the slave modport; the word source / stream observer takes master.
interface mod3_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             data;
    logic             data_valid;
    logic             frame_last;
    logic [1:0]       stream_rem;
    logic             stream_div3;

    modport slave (
        input  in_valid, in_data,
        output in_ready, data, data_valid, frame_last, stream_rem, stream_div3
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, data, data_valid, frame_last, stream_rem, stream_div3
    );
endinterface

// File: rtl/mod3_serial_tx.sv
// mod3_serial_tx: parallel-to-serial transmitter, MSB first, one bit per clock,
// with a running remainder mod 3 of everything sent since reset.
// Optional feature macro MOD3_TX_PAD_EN: append 2 pad bits per frame so every
// frame is a multiple of 3 and stream_rem is 0 at each frame_last.
module mod3_serial_tx #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mod3_serial_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 2);

`ifdef MOD3_TX_PAD_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;     // remaining payload bits, next bit in the MSB
    logic [CW-1:0]    cnt;       // index of the bit currently on data
    logic             data_q;
    logic             dv_q;
    logic             last_q;
    logic [1:0]       rem_q;
    logic             div3_q;
    logic             ready_q;
    logic             accept;

    // rem' = (2*rem + b) mod 3 as a lookup, no arithmetic needed
    function automatic logic [1:0] rem_step(input logic [1:0] r, input logic b);
        case (r)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd0 : 2'd2;
            default: return b ? 2'd2 : 2'd1;
        endcase
    endfunction

`ifdef MOD3_TX_PAD_EN
    logic [1:0] frame_rem;       // payload value mod 3 for the current frame
    logic       pad_lo;          // second pad bit, held while the first is out
    logic [1:0] pad_val;

    // pad p = (3 - r) mod 3; appending 2 bits multiplies by 4 == 1 mod 3
    always_comb begin
        pad_val = 2'd0;
        case (frame_rem)
            2'd1:    pad_val = 2'd2;
            2'd2:    pad_val = 2'd1;
            default: pad_val = 2'd0;
        endcase
    end
`endif

    assign accept          = bus.in_valid && ready_q;
    assign bus.in_ready    = ready_q;
    assign bus.data        = data_q;
    assign bus.data_valid  = dv_q;
    assign bus.frame_last  = last_q;
    assign bus.stream_rem  = rem_q;
    assign bus.stream_div3 = div3_q;

    // Frame FSM; every output is registered alongside the bit it describes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            data_q  <= 1'b0;
            dv_q    <= 1'b0;
            last_q  <= 1'b0;
            rem_q   <= 2'd0;
            div3_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef MOD3_TX_PAD_EN
            frame_rem <= 2'd0;
            pad_lo    <= 1'b0;
`endif
        end else if (accept) begin
            // ready is only high in IDLE or on the final bit, so this also
            // covers the gapless back-to-back reload
            state   <= SHIFT;
            shreg   <= {bus.in_data[WIDTH-2:0], 1'b0};
            cnt     <= CW'(WIDTH - 1);
            data_q  <= bus.in_data[WIDTH-1];
            dv_q    <= 1'b1;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            rem_q   <= rem_step(rem_q, bus.in_data[WIDTH-1]);
            div3_q  <= (rem_step(rem_q, bus.in_data[WIDTH-1]) == 2'd0);
`ifdef MOD3_TX_PAD_EN
            frame_rem <= rem_step(2'd0, bus.in_data[WIDTH-1]);
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (last_q) begin
                        state   <= IDLE;
                        data_q  <= 1'b0;
                        dv_q    <= 1'b0;
                        last_q  <= 1'b0;
                        div3_q  <= 1'b0;
                        ready_q <= 1'b1;
`ifdef MOD3_TX_PAD_EN
                    end else if (cnt == '0) begin
                        state   <= PAD;
                        data_q  <= pad_val[1];
                        pad_lo  <= pad_val[0];
                        rem_q   <= rem_step(rem_q, pad_val[1]);
                        div3_q  <= (rem_step(rem_q, pad_val[1]) == 2'd0);
`endif
                    end else begin
                        data_q <= shreg[WIDTH-1];
                        shreg  <= {shreg[WIDTH-2:0], 1'b0};
                        cnt    <= cnt - CW'(1);
                        rem_q  <= rem_step(rem_q, shreg[WIDTH-1]);
                        div3_q <= (rem_step(rem_q, shreg[WIDTH-1]) == 2'd0);
`ifdef MOD3_TX_PAD_EN
                        frame_rem <= rem_step(frame_rem, shreg[WIDTH-1]);
`else
                        last_q  <= (cnt == CW'(1));
                        ready_q <= (cnt == CW'(1));
`endif
                    end
                end
`ifdef MOD3_TX_PAD_EN
                PAD: begin
                    if (last_q) begin
                        state   <= IDLE;
                        data_q  <= 1'b0;
                        dv_q    <= 1'b0;
                        last_q  <= 1'b0;
                        div3_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        data_q  <= pad_lo;
                        last_q  <= 1'b1;
                        ready_q <= 1'b1;
                        rem_q   <= rem_step(rem_q, pad_lo);
                        div3_q  <= (rem_step(rem_q, pad_lo) == 2'd0);
                    end
                end
`endif
                default: begin
                    // idle: stream value, and so stream_rem, is untouched
                    data_q  <= 1'b0;
                    dv_q    <= 1'b0;
                    last_q  <= 1'b0;
                    div3_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mod3_serial_tx.sv
// tb_mod3_serial_tx: directed tables plus random traffic against a queue-based
// model of the bit stream; the stream remainder is plain integer arithmetic.
module tb_mod3_serial_tx;
    localparam int W = 8;
`ifdef MOD3_TX_PAD_EN
    localparam int PADN = 2;
`else
    localparam int PADN = 0;
`endif
    localparam int FL = W + PADN;

    typedef bit bitq_t[$];
    typedef struct {
        logic       d;
        logic [1:0] rem;
        logic       div3;
        logic       last;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mod3_serial_tx_if #(.WIDTH(W)) bus ();
    mod3_serial_tx #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int    total = 0;
    int    bad = 0;
    bitq_t mq;          // bits of the current frame, front = bit on data now
    int    m_rem = 0;   // stream value since reset, mod 3
    bit    m_acc = 0;
    logic  pre_last;
    vec_t  tv [FL];
    logic [W-1:0] tbl_word;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bitq_t frame_bits(input logic [W-1:0] w);
        bitq_t q;
        int    p;
        for (int i = W - 1; i >= 0; i--) q.push_back(w[i]);
`ifdef MOD3_TX_PAD_EN
        p = (3 - (int'(w) % 3)) % 3;
        q.push_back(bit'((p >> 1) & 1));
        q.push_back(bit'(p & 1));
`else
        p = 0;
`endif
        return q;
    endfunction

    task automatic check_outputs();
        bit busy;
        busy = (mq.size() > 0);
        chk("data_valid", bus.data_valid, busy);
        chk("data", bus.data, busy ? mq[0] : 1'b0);
        chk("frame_last", bus.frame_last, mq.size() == 1);
        chk("in_ready", bus.in_ready, mq.size() <= 1);
        chk("stream_rem", bus.stream_rem, m_rem);
        chk("stream_div3", bus.stream_div3, busy && m_rem == 0);
    endtask

    // one clock: advance the model at the edge, compare on the falling edge
    task automatic tick();
        pre_last = bus.frame_last;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_rem = 0;
            m_acc = 0;
        end else begin
            m_acc = bus.in_valid && (mq.size() <= 1);
            if (m_acc) mq = frame_bits(bus.in_data);
            else if (mq.size() > 0) void'(mq.pop_front());
            if (mq.size() > 0) m_rem = (2 * m_rem + int'(mq[0])) % 3;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_accept(input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 60);
        chk(nm, m_acc, 1'b1);
    endtask

    initial begin
        int   n, dvc, viol;
        int   rem1;
        bit   got2, seen;
        logic [W+1:0] got;

        // expected per-bit outputs of the first frame after reset
`ifdef MOD3_TX_PAD_EN
        tbl_word = 8'h05;   // 00000101 + pad 01
        tv[0] = '{1'b0, 2'd0, 1'b1, 1'b0};
        tv[1] = '{1'b0, 2'd0, 1'b1, 1'b0};
        tv[2] = '{1'b0, 2'd0, 1'b1, 1'b0};
        tv[3] = '{1'b0, 2'd0, 1'b1, 1'b0};
        tv[4] = '{1'b0, 2'd0, 1'b1, 1'b0};
        tv[5] = '{1'b1, 2'd1, 1'b0, 1'b0};
        tv[6] = '{1'b0, 2'd2, 1'b0, 1'b0};
        tv[7] = '{1'b1, 2'd2, 1'b0, 1'b0};
        tv[8] = '{1'b0, 2'd1, 1'b0, 1'b0};
        tv[9] = '{1'b1, 2'd0, 1'b1, 1'b1};
`else
        tbl_word = 8'h03;
        tv[0] = '{1'b0, 2'd0, 1'b1, 1'b0};
        tv[1] = '{1'b0, 2'd0, 1'b1, 1'b0};
        tv[2] = '{1'b0, 2'd0, 1'b1, 1'b0};
        tv[3] = '{1'b0, 2'd0, 1'b1, 1'b0};
        tv[4] = '{1'b0, 2'd0, 1'b1, 1'b0};
        tv[5] = '{1'b0, 2'd0, 1'b1, 1'b0};
        tv[6] = '{1'b1, 2'd1, 1'b0, 1'b0};
        tv[7] = '{1'b1, 2'd0, 1'b1, 1'b1};
`endif

        // reset and idle
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_ready", bus.in_ready, 1'b1);
        chk("idle_rem", bus.stream_rem, 2'd0);

        // first frame against the table
        bus.in_valid = 1'b1;
        bus.in_data  = tbl_word;
        tick();
        chk("tbl_accept", m_acc, 1'b1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("tbl_data[%0d]", i), bus.data, tv[i].d);
            chk($sformatf("tbl_rem[%0d]", i), bus.stream_rem, tv[i].rem);
            chk($sformatf("tbl_div3[%0d]", i), bus.stream_div3, tv[i].div3);
            chk($sformatf("tbl_last[%0d]", i), bus.frame_last, tv[i].last);
            tick();
        end

`ifdef MOD3_TX_PAD_EN
        // 8'h04: payload mod 3 = 1, pad 10
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h04;
        wait_accept("pad04_accept");
        bus.in_valid = 1'b0;
        got = '0;
        for (int i = 0; i < FL; i++) begin
            got = {got[W:0], bus.data};
            if (bus.frame_last) chk("pad04_rem_last", bus.stream_rem, 2'd0);
            tick();
        end
        chk("pad04_bits", got, 10'b0000010010);
`endif

        // back-to-back 05 then 01 with in_valid held
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h05;
        wait_accept("b2b_acc1");
        bus.in_data = 8'h01;
        n = 0; dvc = 0; rem1 = -1; got2 = 0;
        while (n < 60) begin
            if (bus.data_valid) dvc++;
            else break;
            if (bus.frame_last && rem1 < 0) rem1 = int'(bus.stream_rem);
            tick();
            n++;
            if (m_acc && !got2) begin
                got2 = 1;
                chk("b2b_acc2_on_last", pre_last, 1'b1);
                bus.in_valid = 1'b0;
            end
        end
        chk("b2b_second_accepted", got2, 1'b1);
        chk("b2b_contig_valid", dvc, 2 * FL);
        chk("b2b_rem_frame1", rem1, (PADN != 0) ? 0 : 2);
        chk("b2b_rem_final", bus.stream_rem, 2'd0);

        // backpressure: AA waits for the last bit of FF
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        wait_accept("bp_acc_ff");
        bus.in_data = 8'hAA;
        n = 0; viol = 0;
        while (n < 40) begin
            if (bus.in_ready && !bus.frame_last) viol++;
            tick();
            n++;
            if (m_acc) break;
        end
        bus.in_valid = 1'b0;
        chk("bp_ready_low", viol, 0);
        chk("bp_accept_cycle", n, FL);
        chk("bp_next_valid", bus.data_valid, 1'b1);
        chk("bp_next_msb", bus.data, 1'b1);
        n = 0;
        while (bus.data_valid && n < 40) begin tick(); n++; end
        chk("bp_drained", bus.data_valid, 1'b0);

        // reset in the middle of B7
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB7;
        wait_accept("rst_acc_b7");
        bus.in_valid = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dv", bus.data_valid, 1'b0);
        chk("rst_rem", bus.stream_rem, 2'd0);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_last", bus.frame_last, 1'b0);
        mq.delete();
        m_rem = 0;
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h06;
        wait_accept("rst_acc_06");
        bus.in_valid = 1'b0;
        n = 0; seen = 0;
        while (n < 40 && !seen) begin
            if (bus.frame_last) begin
                seen = 1;
                chk("rst_06_rem_last", bus.stream_rem, 2'd0);
            end
            tick();
            n++;
        end
        chk("rst_06_last_seen", seen, 1'b1);

        // random traffic; in_data churns every cycle, sampled only on accept
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = W'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (FL + 3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mod3_serial_tx.md
Name: mod3_serial_tx

Overview:
- Parallel-to-serial transmitter that drives the MSB-first serial divisibility-by-3 detection path.
- Accepts WIDTH-bit words on a valid/ready handshake and shifts each out MSB-first, one bit per clock, on `data` qualified by `data_valid`.
- Tracks the running remainder mod 3 of the whole bit stream sent since reset, i.e. the same quantity the downstream detector computes.
- Serves as stimulus source and scoreboard reference for the detector.

Parameters:
- WIDTH, 8, payload bits per frame; legal range is 2 or more.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  `in_data` is offered.
- in_data  input  WIDTH  word to transmit, MSB first.
- in_ready  output  1  transmitter can accept a word this cycle.
- data  output  1  serial bit; registered.
- data_valid  output  1  `data` carries a stream bit this cycle; the sink must not sample when low.
- frame_last  output  1  current bit is the final bit of its frame.
- stream_rem  output  2  (stream value through the current bit) mod 3; range 0..2.
- stream_div3  output  1  `data_valid` && `stream_rem` == 0.

Behaviour:
- Reset (async assert, sync release): state IDLE, shift register 0, bit counter 0, `data`=0, `data_valid`=0, `frame_last`=0, `stream_rem`=0, `stream_div3`=0, `in_ready`=1.
- FSM states: IDLE, SHIFT (plus PAD only with the optional feature).
- Handshake:
  - Accept when `in_valid` && `in_ready`.
  - `in_ready` = (state==IDLE) || (state==SHIFT && `frame_last` && no PAD phase follows).
  - Accepting in the last-bit cycle enables back-to-back frames with no gap cycle.
- Latency: a word accepted at edge N has its MSB on `data` with `data_valid`=1 in the cycle after edge N; the remaining bits follow on consecutive cycles.
- Frame length: WIDTH cycles. `frame_last`=1 only on bit index 0, the LSB.
- Remainder update, on every edge that emits a bit b: `stream_rem` <= (2*`stream_rem` + b) mod 3.
  - The remainder is computed from the old value and the next bit, so `stream_rem` is registered together with `data`.
  - Use a 2-bit table, not a multiplier: rem0 -> 0/1, rem1 -> 2/0, rem2 -> 1/2, for b=0/b=1.
- `stream_rem` is held whenever `data_valid`=0. Idle cycles do not alter the stream value; this matches a detector whose enable is gated by `data_valid`.
- `stream_div3` equals the detector's success output one cycle earlier.
- Transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT on last bit with accept; the new word loads and the counter reloads to WIDTH-1.
  - SHIFT -> IDLE on last bit without accept.
- Outputs while IDLE: `data`=0, `data_valid`=0, `frame_last`=0.
- `in_data` is sampled only on accept; changes while busy are ignored.
- `in_valid` held high while busy: the word is not accepted until the next `in_ready`.
- Reset mid-frame: the frame is aborted, no further bits are emitted, and `stream_rem` returns to 0.
- Bit counter width: $clog2(WIDTH+2).

Optional Feature:
- Macro: MOD3_TX_PAD_EN.
- Defined:
  - After the WIDTH payload bits, the FSM enters PAD and emits 2 extra bits p[1:0], MSB first.
  - p = (3 - r) mod 3, where r is the payload value mod 3, tracked per frame.
  - Since 4 ≡ 1 mod 3, every (WIDTH+2)-bit frame is a multiple of 3, so `stream_rem`=0 at every `frame_last`.
  - `frame_last` moves to the second pad bit, and `in_ready` asserts only in that cycle or in IDLE.
- Undefined: the PAD state and the per-frame remainder logic are absent; frames are exactly WIDTH bits.

Test Plan:
1. Reset, then idle 5 cycles -> all outputs at reset values, `in_ready`=1, `stream_rem` stays 0.
2. Send 8'h03 from reset.
   - `data` sequence is 0,0,0,0,0,0,1,1.
   - `stream_rem` sequence is 0,0,0,0,0,0,1,0.
   - `stream_div3`=1 on bits 1-6 and bit 8, 0 on bit 7.
   - `frame_last` is on bit 8 only.
3. Back-to-back 8'h05 then 8'h01, `in_valid` continuous.
   - Exactly 16 contiguous `data_valid` cycles.
   - Second accept occurs on the first frame's last-bit cycle.
   - Final `stream_rem`=0, since 0x0501 = 1281 = 3*427.
   - `stream_rem`=2 at the end of the first frame.
4. Backpressure: assert `in_valid` with 8'hAA during frame 8'hFF -> `in_ready` is 0 until the last bit of 8'hFF, and 8'hAA starts the next cycle with no gap.
5. Assert `rst_n` low at bit 4 of 8'hB7 -> immediately `data_valid`=0 and `stream_rem`=0. After release, 8'h06 transmits cleanly and `stream_rem`=0 at `frame_last`.
6. With MOD3_TX_PAD_EN, send 8'h05.
   - 10 bits: 00000101 followed by pad 01, since 5 mod 3 = 2 gives p = 1.
   - `stream_rem`=0 at `frame_last` on bit 10.
   - Sending 8'h04 afterwards gives pad 10 and `stream_rem`=0 again.
